// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
//   Shared definitions for the immediate-extension stage: mode encodings and
//   the width-generic extension function used by the decode/execute path.
//   The function works on MAX_W-bit containers so that it can live in a
//   package and still serve any IN_W/OUT_W/SHIFT combination. Callers pass
//   their widths and slice the low OUT_W bits of the result.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

  localparam int MAX_W = 64;

  localparam logic [1:0] MODE_ZERO     = 2'd0;
  localparam logic [1:0] MODE_SIGN     = 2'd1;
  localparam logic [1:0] MODE_SIGN_SHL = 2'd2;
  localparam logic [1:0] MODE_UPPER    = 2'd3;

  // Returns {trunc, value}. value is MAX_W bits wide; bits above out_w are
  // don't-care for the caller.
  function automatic logic [MAX_W:0] ext_imm(
    input logic [MAX_W-1:0] imm,
    input logic [1:0]       mode,
    input int               in_w,
    input int               out_w,
    input int               shift
  );
    logic [MAX_W-1:0] zx;
    logic [MAX_W-1:0] sx;
    logic [MAX_W-1:0] shl;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] val;
    logic             trunc;
    zx    = imm & ~({MAX_W{1'b1}} << in_w);
    sx    = $signed(zx << (MAX_W - in_w)) >>> (MAX_W - in_w);
    shl   = sx << shift;
    // Everything from bit out_w-1 upward must be a pure sign run for the
    // shifted value to fit; bits above in_w+shift are sign copies already,
    // so the short-width case (in_w+shift <= out_w) never flags.
    hi    = $signed(shl) >>> (out_w - 1);
    trunc = 1'b0;
    case (mode)
      MODE_ZERO:     val = zx;
      MODE_SIGN:     val = sx;
      MODE_SIGN_SHL: begin
        val   = shl;
        trunc = (hi != '0) && (hi != '1);
      end
      default:       val = zx << (out_w - in_w);
    endcase
    return {trunc, val};
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// -----------------------------------------------------------------------------
// skid_buf2
//   Generic 2-entry valid/ready skid buffer with synchronous flush.
//   Main register drives the output; the skid register catches an accept that
//   lands while main is full and stalled. in_ready is a flop (= !skid_valid),
//   so there is no combinational path from out_ready to in_ready.
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               invalidate both entries at the next edge
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
// -----------------------------------------------------------------------------
module skid_buf2 #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_accept;
  logic              w_xfer;
  logic              w_main_valid_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = r_main_valid & out_ready;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_data_nxt  = r_skid_data;
    if (!r_main_valid || w_xfer) begin
      // Main frees up this edge: skid drains first (accept is impossible
      // while skid is full since in_ready is low), else take the new item.
      if (r_skid_valid) begin
        w_main_data_nxt  = r_skid_data;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_data_nxt  = in_data;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_data_nxt  = in_data;
      w_skid_valid_nxt = 1'b1;
    end
    // Transfer on this edge still happens downstream; only held state clears.
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

endmodule

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//   Pipelined immediate extension: widens an IN_W-bit immediate to OUT_W bits
//   (zero / sign / sign+shift / upper) and registers it with its tag through a
//   2-entry skid buffer. One cycle from accept to out_valid.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   flush                      squash held entries at next edge
//   in_valid/in_ready          upstream handshake
//   in_imm, in_mode, in_tag    raw immediate, extension mode, sideband tag
//   out_valid/out_ready        downstream handshake
//   out_imm, out_tag           extended immediate and its tag
//   out_trunc                  SIGN_SHL result overflowed OUT_W (signed)
// -----------------------------------------------------------------------------
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 6,
  parameter int SHIFT = 3,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_trunc
);

  localparam int DATA_W = OUT_W + TAG_W + 1;

  generate
    if (OUT_W < IN_W) begin : g_bad_out_w
      $error("imm_extend_stage: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end
    if (OUT_W >= MAX_W) begin : g_bad_max_w
      $error("imm_extend_stage: OUT_W (%0d) must be < %0d", OUT_W, MAX_W);
    end
  endgenerate

  logic [MAX_W-1:0]  w_imm_wide;
  logic [MAX_W:0]    w_ext;
  logic [DATA_W-1:0] w_in_data;
  logic [DATA_W-1:0] w_out_data;
  logic              w_unused;

  assign w_imm_wide = MAX_W'(in_imm);
  assign w_ext      = ext_imm(w_imm_wide, in_mode, IN_W, OUT_W, SHIFT);
  assign w_in_data  = {w_ext[MAX_W], w_ext[OUT_W-1:0], in_tag};
  assign w_unused   = ^w_ext[MAX_W-1:OUT_W];

  skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (w_in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_out_data)
  );

  assign {out_trunc, out_imm, out_tag} = w_out_data;

endmodule

// File: tb/tb_imm_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_stage
//   Directed bench for imm_extend_stage at IN_W=4, OUT_W=6, SHIFT=3, TAG_W=5.
//   Inputs change 1 time unit after the rising edge; checks happen there too.
//   A negedge monitor logs every output transfer with its cycle number.
// -----------------------------------------------------------------------------
module tb_imm_extend_stage;

  localparam int IN_W  = 4;
  localparam int OUT_W = 6;
  localparam int SHIFT = 3;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_trunc;

  int n_checks;
  int n_fail;
  int cyc;

  logic [TAG_W-1:0] rx_tag_q[$];
  int               rx_cyc_q[$];

  imm_extend_stage #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_tag  (out_tag),
    .out_trunc(out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_tag_q.push_back(out_tag);
      rx_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string name, input logic [1:0] m, input logic [3:0] imm,
                         input logic [4:0] tag, input logic [5:0] exp_imm, input logic exp_tr);
    chk({name, "_pre_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_imm   = imm;
    in_tag   = tag;
    nxt();
    in_valid = 1'b0;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_imm"},   32'(out_imm),   32'(exp_imm));
    chk({name, "_tag"},   32'(out_tag),   32'(tag));
    chk({name, "_trunc"}, 32'(out_trunc), 32'(exp_tr));
    nxt();
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic acc;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'd0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    nxt();
    nxt();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_imm",   32'(out_imm),   32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    chk("rst_out_trunc", 32'(out_trunc), 32'd0);
    rst_n = 1'b1;
    nxt();

    // Extension modes
    run_vec("sign_neg",  2'd1, 4'b1110, 5'd3,  6'b111110, 1'b0);
    run_vec("zero",      2'd0, 4'b1110, 5'd7,  6'b001110, 1'b0);
    run_vec("upper",     2'd3, 4'b1110, 5'd11, 6'b111000, 1'b0);
    run_vec("sign_pos",  2'd1, 4'b0100, 5'd20, 6'b000100, 1'b0);
    run_vec("sign_min",  2'd1, 4'b1000, 5'd5,  6'b111000, 1'b0);
    run_vec("upper_05",  2'd3, 4'b0101, 5'd30, 6'b010100, 1'b0);
    run_vec("shl_ovf",   2'd2, 4'b0110, 5'd1,  6'b110000, 1'b1);
    run_vec("shl_neg",   2'd2, 4'b1110, 5'd2,  6'b110000, 1'b0);
    run_vec("shl_one",   2'd2, 4'b0001, 5'd31, 6'b001000, 1'b0);
    run_vec("shl_ovfn",  2'd2, 4'b1010, 5'd4,  6'b010000, 1'b1);

    // Back-pressure: tags 1,2,3 with out_ready low
    rx_tag_q.delete();
    rx_cyc_q.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 4'd1;
    in_tag    = 5'd1;
    nxt();
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_ready", 32'(in_ready),  32'd1);
    in_tag = 5'd2;
    in_imm = 4'd2;
    nxt();
    chk("bp_full_ready",  32'(in_ready), 32'd0);
    chk("bp_hold_tag_a",  32'(out_tag),  32'd1);
    in_tag = 5'd3;
    in_imm = 4'd3;
    nxt();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_tag_b",  32'(out_tag),  32'd1);
    chk("bp_hold_imm",    32'(out_imm),  32'd1);
    nxt();
    chk("bp_hold_tag_c",  32'(out_tag),  32'd1);
    chk("bp_hold_valid",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      acc = in_valid & in_ready;
      nxt();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 32'(rx_tag_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < rx_tag_q.size()) chk($sformatf("bp_order_%0d", k), 32'(rx_tag_q[k]), 32'(k + 1));
    end
    in_valid = 1'b0;

    // Streaming 16 back-to-back
    rx_tag_q.delete();
    rx_cyc_q.delete();
    in_valid = 1'b1;
    in_mode  = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in_tag = 5'(i);
      in_imm = 4'(i);
      chk($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
      nxt();
    end
    in_valid = 1'b0;
    nxt();
    nxt();
    nxt();
    chk("stream_count", 32'(rx_tag_q.size()), 32'd16);
    if (rx_tag_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("stream_tag_%0d", i), 32'(rx_tag_q[i]), 32'(i));
        chk($sformatf("stream_cyc_%0d", i), 32'(rx_cyc_q[i] - rx_cyc_q[0]), 32'(i));
      end
    end

    // Flush with both entries full and in_valid high
    rx_tag_q.delete();
    rx_cyc_q.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd10;
    nxt();
    in_tag = 5'd11;
    nxt();
    chk("fl_full_ready", 32'(in_ready),  32'd0);
    chk("fl_full_valid", 32'(out_valid), 32'd1);
    flush  = 1'b1;
    in_tag = 5'd12;
    nxt();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready",  32'(in_ready),  32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nxt();
    nxt();
    nxt();
    chk("fl_nothing_out", 32'(rx_tag_q.size()), 32'd0);

    // Flush while an accept lands: the accepted item is discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd13;
    nxt();
    chk("fl2_ready", 32'(in_ready), 32'd1);
    flush  = 1'b1;
    in_tag = 5'd14;
    nxt();
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_in_ready",  32'(in_ready),  32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nxt();
    nxt();
    nxt();
    chk("fl2_nothing_out", 32'(rx_tag_q.size()), 32'd0);

    run_vec("post_flush", 2'd1, 4'b1001, 5'd17, 6'b111001, 1'b0);

    // Async reset mid-stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'd2;
    in_imm    = 4'b0110;
    in_tag    = 5'd9;
    nxt();
    nxt();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_trunc", 32'(out_trunc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    chk("ar_out_imm",   32'(out_imm),   32'd0);
    chk("ar_out_tag",   32'(out_tag),   32'd0);
    chk("ar_out_trunc", 32'(out_trunc), 32'd0);
    in_valid = 1'b0;
    rx_tag_q.delete();
    rx_cyc_q.delete();
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
    nxt();
    nxt();
    nxt();
    chk("ar_no_output", 32'(rx_tag_q.size()), 32'd0);
    chk("ar_idle_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
